rosc_odometer_seq: RTL and testbench

Parametrised stress/measure sequencer for a bank of NUM_CH ring-oscillator odometer channels. It drives the power, enable, select and stress-mode controls of the oscillator chains. It runs a timed stress phase in DC mode or in AC mode, using an internally generated stress clock. It then measures each enabled channel in turn by counting synchronised oscillator edges over a fixed window, and returns one count per channel over a valid/ready result port.

---
 rtl/rosc_odometer_seq_if.sv | 34 +++
 rtl/rosc_odometer_seq.sv | 205 ++++++++++++++++++++
 tb/tb_rosc_odometer_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rosc_odometer_seq_if.sv
// Control, configuration and result bundle for the ring-oscillator odometer sequencer.
// The sequencer attaches through the slave modport; the controlling agent uses master.
interface rosc_odometer_seq_if #(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned LEN_W    = 20,
    parameter int unsigned AC_DIV_W = 4
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                start;
    logic                abort;
    logic                ac_dc;
    logic [NUM_CH-1:0]   ch_mask;
    logic [LEN_W-1:0]    stress_len;
    logic [LEN_W-1:0]    meas_len;
    logic [AC_DIV_W-1:0] ac_half;
    logic                busy;
    logic                done;
    logic                res_valid;
    logic [CH_W-1:0]     res_ch;
    logic [CNT_W-1:0]    res_count;
    logic                res_ready;

    modport master (
        output start, abort, ac_dc, ch_mask, stress_len, meas_len, ac_half, res_ready,
        input  busy, done, res_valid, res_ch, res_count
    );

    modport slave (
        input  start, abort, ac_dc, ch_mask, stress_len, meas_len, ac_half, res_ready,
        output busy, done, res_valid, res_ch, res_count
    );
endinterface

// File: rtl/rosc_odometer_seq.sv
// Stress/measure sequencer for a bank of ring-oscillator odometer channels: a timed DC/AC
// stress phase, then a per-channel synchronised edge count reported over valid/ready.
module rosc_odometer_seq #(
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned LEN_W    = 20,
    parameter int unsigned AC_DIV_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    rosc_odometer_seq_if.slave bus,
    input  logic [NUM_CH-1:0]  rosc_in,
    output logic [NUM_CH-1:0]  en_power_rosc,
    output logic [NUM_CH-1:0]  en_rosc,
    output logic [NUM_CH-1:0]  sel,
    output logic               meas_stress,
    output logic               ac_stress_clk
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {StIdle, StStress, StSettle, StMeas, StReport} state_e;

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [LEN_W-1:0]    stress_len_q, meas_len_q, cyc_q, cyc_d;
    logic [AC_DIV_W-1:0] ac_half_q, ac_cnt_q;
    logic                ac_mode_q, ac_q;
    logic [CH_W-1:0]     ptr_q, ptr_d, first_ch, next_ch;
    logic                has_next, done_d, start_run, meas_entry;
    logic                sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_CH-1:0]   en_power_q, en_rosc_q, sel_q, en_power_d, en_rosc_d, sel_d, onehot;
    logic                meas_stress_q, busy_q, done_q, valid_q;

    assign start_run  = (state_q == StIdle) && bus.start && !bus.abort;
    assign mask_d     = start_run ? bus.ch_mask : mask_q;
    assign meas_entry = (state_d == StMeas) && (state_q != StMeas);

    // Lowest set mask bit, and the next set bit above the current pointer.
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        has_next = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i]) first_ch = CH_W'(i);
            if (mask_q[i] && (i > int'(ptr_q))) begin
                next_ch  = CH_W'(i);
                has_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.ch_mask == '0)          done_d  = 1'b1;
                    else if (bus.stress_len != '0)  state_d = StStress;
                    else                            state_d = StSettle;
                end
            end
            StStress: if (cyc_q == stress_len_q - LEN_W'(1)) state_d = StSettle;
            StSettle: if (cyc_q == LEN_W'(3)) state_d = StMeas;
            StMeas: begin
                if ((meas_len_q == '0) || (cyc_q == meas_len_q - LEN_W'(1))) state_d = StReport;
            end
            StReport: begin
                if (bus.res_ready) begin
                    if (has_next) begin
                        state_d = StMeas;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (bus.abort) begin
            state_d = StIdle;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        cyc_d = cyc_q;
        if (state_d != state_q) cyc_d = '0;
        else if (state_q inside {StStress, StSettle, StMeas}) cyc_d = cyc_q + LEN_W'(1);

        ptr_d = ptr_q;
        if (state_d == StIdle) ptr_d = '0;
        else if (state_q == StSettle) ptr_d = first_ch;
        else if ((state_q == StReport) && (state_d == StMeas)) ptr_d = next_ch;

        onehot     = NUM_CH'(1) << ptr_d;
        en_power_d = '0;
        en_rosc_d  = '0;
        sel_d      = '0;
        unique case (state_d)
            StStress: begin
                en_power_d = mask_d;
                en_rosc_d  = mask_d;
            end
            StSettle, StReport: en_power_d = '1;
            StMeas: begin
                en_power_d = '1;
                en_rosc_d  = onehot;
                sel_d      = onehot;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            mask_q       <= '0;
            stress_len_q <= '0;
            meas_len_q   <= '0;
            ac_half_q    <= '0;
            ac_mode_q    <= 1'b0;
            cyc_q        <= '0;
            ptr_q        <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            ptr_q   <= ptr_d;
            if (start_run) begin
                mask_q       <= bus.ch_mask;
                stress_len_q <= bus.stress_len;
                meas_len_q   <= bus.meas_len;
                ac_half_q    <= bus.ac_half;
                ac_mode_q    <= bus.ac_dc;
            end
        end
    end

    // Synchroniser and counter restart on every MEAS entry so a channel switch adds no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else if ((state_d == StIdle) || meas_entry) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (state_q == StMeas) begin
            sync1_q <= rosc_in[ptr_q];
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (sync2_q && !prev_q && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ac_q     <= 1'b0;
            ac_cnt_q <= '0;
        end else if ((state_d != StStress) || (state_q != StStress)) begin
            ac_q     <= 1'b0;
            ac_cnt_q <= '0;
        end else if (ac_cnt_q == ac_half_q) begin
            ac_q     <= ac_mode_q & ~ac_q;
            ac_cnt_q <= '0;
        end else begin
            ac_cnt_q <= ac_cnt_q + AC_DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_power_q    <= '0;
            en_rosc_q     <= '0;
            sel_q         <= '0;
            meas_stress_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            en_power_q    <= en_power_d;
            en_rosc_q     <= en_rosc_d;
            sel_q         <= sel_d;
            meas_stress_q <= state_d inside {StSettle, StMeas, StReport};
            busy_q        <= state_d != StIdle;
            done_q        <= done_d;
            valid_q       <= state_d == StReport;
        end
    end

    assign en_power_rosc = en_power_q;
    assign en_rosc       = en_rosc_q;
    assign sel           = sel_q;
    assign meas_stress   = meas_stress_q;
    assign ac_stress_clk = ac_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.res_valid = valid_q;
    assign bus.res_ch    = ptr_q;
    assign bus.res_count = cnt_q;
endmodule

// File: tb/tb_rosc_odometer_seq.sv
// Scoreboard bench for rosc_odometer_seq: directed runs push expected results, a monitor
// pops them on each accepted result; a CNT_W=4 copy checks counter saturation.
module tb_rosc_odometer_seq;
    typedef struct {
        int ch;
        int lo;
        int hi;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] rosc;
    logic [2:0] en_power_rosc, en_rosc, sel;
    logic       meas_stress, ac_stress_clk;
    logic [2:0] s_en_power_rosc, s_en_rosc, s_sel;
    logic       s_meas_stress, s_ac_stress_clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_done = 0;
    int   n_sat  = 0;
    bit   sat_phase = 0;
    exp_t sb_q[$];

    rosc_odometer_seq_if #(.NUM_CH(3), .CNT_W(16), .LEN_W(20), .AC_DIV_W(4)) bif ();
    rosc_odometer_seq_if #(.NUM_CH(3), .CNT_W(4),  .LEN_W(20), .AC_DIV_W(4)) sif ();

    rosc_odometer_seq #(.NUM_CH(3), .CNT_W(16), .LEN_W(20), .AC_DIV_W(4)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bif),
        .rosc_in       (rosc),
        .en_power_rosc (en_power_rosc),
        .en_rosc       (en_rosc),
        .sel           (sel),
        .meas_stress   (meas_stress),
        .ac_stress_clk (ac_stress_clk)
    );

    rosc_odometer_seq #(.NUM_CH(3), .CNT_W(4), .LEN_W(20), .AC_DIV_W(4)) u_sat (
        .clk           (clk),
        .rst           (rst),
        .bus           (sif),
        .rosc_in       (rosc),
        .en_power_rosc (s_en_power_rosc),
        .en_rosc       (s_en_rosc),
        .sel           (s_sel),
        .meas_stress   (s_meas_stress),
        .ac_stress_clk (s_ac_stress_clk)
    );

    assign sif.start      = bif.start;
    assign sif.abort      = bif.abort;
    assign sif.ac_dc      = bif.ac_dc;
    assign sif.ch_mask    = bif.ch_mask;
    assign sif.stress_len = bif.stress_len;
    assign sif.meas_len   = bif.meas_len;
    assign sif.ac_half    = bif.ac_half;
    assign sif.res_ready  = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oscillators at CLK/4, CLK/6 and CLK/10, phased away from clock edges.
    initial begin
        rosc = 3'b000;
        #3;
        fork
            forever #20 rosc[0] = ~rosc[0];
            forever #30 rosc[1] = ~rosc[1];
            forever #50 rosc[2] = ~rosc[2];
        join
    end

    function automatic logic [31:0] outs_main();
        return {en_power_rosc, en_rosc, sel, meas_stress, ac_stress_clk, bif.busy, bif.done,
                bif.res_valid, bif.res_ch, bif.res_count};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind 0: res_valid, 1: not busy, 2: sel equals m
    task automatic wait_cond(input string name, input int kind, input logic [2:0] m,
                             input int limit);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk);
            case (kind)
                0:       hit = bif.res_valid;
                1:       hit = !bif.busy;
                default: hit = (sel == m);
            endcase
        end
        n_cmp++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: got no event, expected it within %0d cycles", name, limit);
        end
    endtask

    task automatic start_run(input logic [2:0] m, input bit ac, input int slen, input int mlen,
                             input int half);
        bif.ch_mask    = m;
        bif.ac_dc      = ac;
        bif.stress_len = 20'(slen);
        bif.meas_len   = 20'(mlen);
        bif.ac_half    = 4'(half);
        bif.start      = 1'b1;
        tick();
        bif.start      = 1'b0;
    endtask

    // Counts stress cycles and those whose outputs differ from the expected stress pattern.
    task automatic measure_stress(input logic [2:0] m, input bit ac, input int half,
                                  output int ncyc, output int nbad);
        logic exp_ac;
        ncyc = 0;
        nbad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (meas_stress || !bif.busy) break;
            exp_ac = ac ? 1'((ncyc / (half + 1)) % 2) : 1'b0;
            if (ac_stress_clk !== exp_ac || en_power_rosc !== m || en_rosc !== m || sel !== 3'b0)
                nbad++;
            ncyc++;
        end
    endtask

    // Result monitor: scoreboard pops on handshake, stability while stalled.
    initial begin
        exp_t       e;
        bit         hold_v;
        logic [1:0] hold_ch;
        logic [15:0] hold_cnt;
        hold_v = 1'b0;
        forever begin
            @(negedge clk);
            if (bif.done) n_done++;
            if (bif.res_valid && hold_v) begin
                n_cmp++;
                if (bif.res_ch !== hold_ch || bif.res_count !== hold_cnt) begin
                    n_fail++;
                    $display("FAIL result_stable: got ch%0d count %0d, expected ch%0d count %0d",
                             bif.res_ch, bif.res_count, hold_ch, hold_cnt);
                end
            end
            if (bif.res_valid && bif.res_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result: got ch%0d count %0d, expected no result",
                             bif.res_ch, bif.res_count);
                end else begin
                    e = sb_q.pop_front();
                    n_cmp++;
                    if (int'(bif.res_ch) != e.ch) begin
                        n_fail++;
                        $display("FAIL res_ch: got %0d, expected %0d", bif.res_ch, e.ch);
                    end
                    n_cmp++;
                    if (int'(bif.res_count) < e.lo || int'(bif.res_count) > e.hi) begin
                        n_fail++;
                        $display("FAIL res_count_ch%0d: got %0d, expected %0d..%0d",
                                 e.ch, bif.res_count, e.lo, e.hi);
                    end
                end
            end
            hold_v   = bif.res_valid && !bif.res_ready;
            hold_ch  = bif.res_ch;
            hold_cnt = bif.res_count;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sif.res_valid && sat_phase) begin
                n_sat++;
                n_cmp++;
                if (sif.res_count !== 4'd15) begin
                    n_fail++;
                    $display("FAIL sat_count: got %0d, expected 15", sif.res_count);
                end
            end
        end
    end

    initial begin
        int ncyc, nbad, d0;
        rst            = 1'b1;
        bif.start      = 1'b0;
        bif.abort      = 1'b0;
        bif.ac_dc      = 1'b0;
        bif.ch_mask    = '0;
        bif.stress_len = '0;
        bif.meas_len   = '0;
        bif.ac_half    = '0;
        bif.res_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs_main(), 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", outs_main(), 32'h0);

        // DC stress, two channels measured
        tick();
        d0 = n_done;
        sb_q.push_back('{ch: 0, lo: 24, hi: 26});
        sb_q.push_back('{ch: 2, lo: 9, hi: 11});
        start_run(3'b101, 1'b0, 10, 100, 0);
        measure_stress(3'b101, 1'b0, 0, ncyc, nbad);
        check("dc_stress_cycles", ncyc, 10);
        check("dc_stress_outputs", nbad, 0);
        check("settle_outputs", {en_power_rosc, en_rosc, sel, meas_stress, ac_stress_clk},
              11'b111_000_000_1_0);
        wait_cond("t1_finish", 1, 3'b0, 500);
        repeat (2) @(negedge clk);
        check("t1_done_once", n_done - d0, 1);
        check("t1_sb_drained", sb_q.size(), 0);

        // AC stress, half period 3 cycles
        tick();
        sb_q.push_back('{ch: 1, lo: 2, hi: 4});
        start_run(3'b010, 1'b1, 24, 20, 2);
        measure_stress(3'b010, 1'b1, 2, ncyc, nbad);
        check("ac_stress_cycles", ncyc, 24);
        check("ac_stress_pattern", nbad, 0);
        check("ac_low_after_stress", ac_stress_clk, 0);
        wait_cond("t2_finish", 1, 3'b0, 200);
        repeat (2) @(negedge clk);
        check("t2_sb_drained", sb_q.size(), 0);

        // Zero-length stress and counter saturation on the narrow copy
        tick();
        sat_phase = 1'b1;
        n_sat     = 0;
        sb_q.push_back('{ch: 0, lo: 49, hi: 51});
        start_run(3'b001, 1'b0, 0, 200, 0);
        @(negedge clk);
        check("stress_len0_settle", {bif.busy, meas_stress, en_rosc}, 5'b1_1_000);
        wait_cond("t3_finish", 1, 3'b0, 600);
        repeat (2) @(negedge clk);
        check("sat_result_seen", n_sat, 1);
        sat_phase = 1'b0;
        check("t3_sb_drained", sb_q.size(), 0);

        // Stalled result stays stable; next MEAS follows the accept
        tick();
        d0 = n_done;
        bif.res_ready = 1'b0;
        sb_q.push_back('{ch: 0, lo: 2, hi: 4});
        sb_q.push_back('{ch: 1, lo: 1, hi: 3});
        start_run(3'b011, 1'b0, 2, 12, 0);
        wait_cond("t4_valid", 0, 3'b0, 100);
        repeat (50) tick();
        bif.res_ready = 1'b1;
        tick();
        @(negedge clk);
        check("next_meas_after_accept", {bif.res_valid, sel, en_rosc}, 7'b0_010_010);
        wait_cond("t4_finish", 1, 3'b0, 100);
        repeat (2) @(negedge clk);
        check("t4_done_once", n_done - d0, 1);
        check("t4_sb_drained", sb_q.size(), 0);

        // Abort during MEAS on channel 1
        tick();
        d0 = n_done;
        start_run(3'b010, 1'b0, 5, 100, 0);
        wait_cond("t5_meas_ch1", 2, 3'b010, 50);
        repeat (10) tick();
        bif.abort = 1'b1;
        tick();
        bif.abort = 1'b0;
        @(negedge clk);
        check("abort_meas_outputs", outs_main(), 32'h0);
        repeat (5) @(negedge clk);
        check("abort_meas_no_done", n_done - d0, 0);

        // Abort during REPORT drops the pending result
        tick();
        d0 = n_done;
        bif.res_ready = 1'b0;
        start_run(3'b001, 1'b0, 0, 8, 0);
        wait_cond("t6_valid", 0, 3'b0, 50);
        repeat (3) tick();
        bif.abort = 1'b1;
        tick();
        bif.abort = 1'b0;
        @(negedge clk);
        check("abort_report_outputs", outs_main(), 32'h0);
        tick();
        bif.res_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_report_no_done", n_done - d0, 0);

        // Normal run after abort; START while busy is ignored
        tick();
        d0 = n_done;
        sb_q.push_back('{ch: 2, lo: 2, hi: 4});
        start_run(3'b100, 1'b0, 20, 30, 0);
        repeat (2) tick();
        bif.ch_mask    = 3'b011;
        bif.stress_len = '0;
        bif.start      = 1'b1;
        tick();
        bif.start      = 1'b0;
        @(negedge clk);
        check("start_busy_ignored", {bif.busy, meas_stress, en_rosc}, 5'b1_0_100);
        wait_cond("t7_finish", 1, 3'b0, 200);
        repeat (2) @(negedge clk);
        check("t7_done_once", n_done - d0, 1);
        check("t7_sb_drained", sb_q.size(), 0);

        // Empty mask: DONE next cycle, no result
        tick();
        d0 = n_done;
        start_run(3'b000, 1'b0, 5, 10, 0);
        @(negedge clk);
        check("mask0_done", {bif.done, bif.busy, bif.res_valid}, 3'b100);
        repeat (3) @(negedge clk);
        check("mask0_single_done", n_done - d0, 1);

        // Asynchronous reset in the middle of STRESS
        tick();
        start_run(3'b111, 1'b0, 50, 10, 0);
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", outs_main(), 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", outs_main(), 32'h0);
        check("final_sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
